// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the lines, deframes 11-bit frames and tracks make/break codes.
// Optional extended-code (E0) tracking with an ext output when PS2_EXT_CODE_EN is defined.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dataout,
  output logic       key_tick,
  output logic       rx_done_tick,
  output logic       frame_err,
`ifdef PS2_EXT_CODE_EN
  output logic       ext,
`endif
  output logic       busy
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          ps2c_s1_reg, ps2c_s2_reg, ps2d_s1_reg, ps2d_s2_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          ps2c_f_reg, ps2c_f_dly_reg;
  logic          fall_tick;

  state_t        state_reg, state_next;
  logic [2:0]    n_reg, n_next;
  logic [7:0]    sh_reg, sh_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [7:0]    byte_reg;
  logic          busy_reg;

  logic [7:0]    dout_reg;
  logic          key_reg;
  logic          brk_reg;
  logic          is_brk, is_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_s1_reg <= 1'b1;
      ps2c_s2_reg <= 1'b1;
      ps2d_s1_reg <= 1'b1;
      ps2d_s2_reg <= 1'b1;
    end else begin
      ps2c_s1_reg <= ps2c;
      ps2c_s2_reg <= ps2c_s1_reg;
      ps2d_s1_reg <= ps2d;
      ps2d_s2_reg <= ps2d_s1_reg;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_reg   <= '0;
      ps2c_f_reg     <= 1'b1;
      ps2c_f_dly_reg <= 1'b1;
    end else begin
      ps2c_f_dly_reg <= ps2c_f_reg;
      if (ps2c_s2_reg == ps2c_f_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_MAX) begin
        ps2c_f_reg   <= ps2c_s2_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign fall_tick = ps2c_f_dly_reg & ~ps2c_f_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      sh_reg    <= '0;
      par_reg   <= 1'b0;
      tcnt_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      byte_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      sh_reg    <= sh_next;
      par_reg   <= par_next;
      tcnt_reg  <= tcnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= (state_next != IDLE);
      if (done_next) byte_reg <= sh_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    sh_next    = sh_reg;
    par_next   = par_reg;
    tcnt_next  = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (state_reg != IDLE && !fall_tick) tcnt_next = tcnt_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        if (fall_tick && rx_en && !ps2d_s2_reg) begin
          state_next = DATA;
          n_next     = '0;
        end
      end
      DATA: begin
        if (fall_tick) begin
          sh_next = {ps2d_s2_reg, sh_reg[7:1]};
          n_next  = n_reg + 3'd1;
          if (n_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall_tick) begin
          par_next   = ps2d_s2_reg;
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall_tick) begin
          state_next = IDLE;
          if ((^{sh_reg, par_reg}) && ps2d_s2_reg) done_next = 1'b1;
          else err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A stalled frame is abandoned; a fall arriving on the last cycle still wins.
    if (state_reg != IDLE && !fall_tick && tcnt_reg == TOUT_MAX) begin
      state_next = IDLE;
      tcnt_next  = '0;
      err_next   = 1'b1;
    end
  end

  assign is_brk = (byte_reg == CODE_BRK);
  assign is_ext = (byte_reg == CODE_EXT);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg <= '0;
      key_reg  <= 1'b0;
      brk_reg  <= 1'b0;
    end else begin
      key_reg <= 1'b0;
      if (done_reg && is_brk) begin
        brk_reg <= 1'b1;
      end else if (done_reg && !is_ext) begin
        if (brk_reg) begin
          brk_reg <= 1'b0;
          if (byte_reg == dout_reg) dout_reg <= 8'h00;
        end else begin
          dout_reg <= byte_reg;
          key_reg  <= 1'b1;
        end
      end
    end
  end

`ifdef PS2_EXT_CODE_EN
  logic pend_reg, ext_reg;

  // E0 prefix survives an intervening F0 so E0 F0 xx releases the extended key.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg <= 1'b0;
      ext_reg  <= 1'b0;
    end else if (done_reg && is_ext) begin
      pend_reg <= 1'b1;
    end else if (done_reg && !is_brk) begin
      pend_reg <= 1'b0;
      if (brk_reg) begin
        if (byte_reg == dout_reg) ext_reg <= 1'b0;
      end else begin
        ext_reg <= pend_reg;
      end
    end
  end

  assign ext = ext_reg;
`endif

  assign dataout      = dout_reg;
  assign key_tick     = key_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = err_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised self-checking bench for ps2_scancode_rx with a behavioural key-state model.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TOUT       = 300;
  localparam int H          = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c, ps2d, rx_en;
  logic [7:0] dataout;
  logic       key_tick, rx_done_tick, frame_err, busy;
`ifdef PS2_EXT_CODE_EN
  logic       ext;
`endif

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dataout(dataout), .key_tick(key_tick), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
`ifdef PS2_EXT_CODE_EN
    .ext(ext),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit started = 0;
  bit busy_seen = 0;

  int         q_kind[$];
  logic [7:0] q_byte[$];

  logic [7:0] m_dout = 8'h00;
  bit         m_brk = 0, m_pend = 0, m_ext = 0, m_key = 0;
  bit         pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key-state model: what a keyboard controller should believe after each valid byte.
  task automatic model_apply(input logic [7:0] b);
    m_key = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) begin
`ifdef PS2_EXT_CODE_EN
      m_pend = 1;
`endif
    end else if (m_brk) begin
      m_brk = 0;
      if (b == m_dout) begin
        m_dout = 8'h00;
        m_ext  = 0;
      end
      m_pend = 0;
    end else begin
      m_dout = b;
      m_ext  = m_pend;
      m_pend = 0;
      m_key  = 1;
    end
  endtask

  always @(negedge clk) begin
    int kind;
    logic [7:0] b;
    if (started && !reset) begin
      if (busy) busy_seen = 1;
      if (rx_done_tick || frame_err) begin
        chk("tick_exclusive", 32'(rx_done_tick & frame_err), 0);
        chk("key_tick_at_done", 32'(key_tick), 0);
        chk("dataout_at_done", 32'(dataout), 32'(m_dout));
        if (q_kind.size() == 0) begin
          chk("unexpected_event", {30'd0, rx_done_tick, frame_err}, 0);
        end else begin
          kind = q_kind.pop_front();
          b    = q_byte.pop_front();
          chk("event_kind", rx_done_tick ? 1 : 2, kind);
          if (rx_done_tick && kind == 1) begin
            model_apply(b);
            pending = 1;
          end
        end
      end else if (pending) begin
        pending = 0;
        chk("key_tick", 32'(key_tick), 32'(m_key));
        chk("dataout", 32'(dataout), 32'(m_dout));
`ifdef PS2_EXT_CODE_EN
        chk("ext", 32'(ext), 32'(m_ext));
`endif
      end else begin
        chk("key_tick_idle", 32'(key_tick), 0);
        chk("dataout_hold", 32'(dataout), 32'(m_dout));
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int nb, input bit drop_en);
    for (int i = 0; i < nb; i++) begin
      ps2d = bits[i];
      repeat (H/2) @(negedge clk);
      ps2c = 1'b0;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
      if (drop_en && i == 0) rx_en = 1'b0;
      repeat (H/2) @(negedge clk);
    end
    ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit perr, input bit stop, input bit en, input bit drop);
    logic par;
    par = ~(^b) ^ perr;
    if (en) begin
      q_kind.push_back((!perr && stop) ? 1 : 2);
      q_byte.push_back(b);
    end
    rx_en = en;
    send_bits({stop, par, b, 1'b0}, 11, drop);
    repeat (80) @(negedge clk);
    chk("missing_event", q_kind.size(), 0);
    q_kind.delete();
    q_byte.delete();
    rx_en = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [4];
    logic [7:0] last_make;
    logic [7:0] b;
    int sel;
    pool[0] = 8'h1C; pool[1] = 8'h23; pool[2] = 8'h1B; pool[3] = 8'h2B;
    last_make = 8'h1C;

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_dataout", 32'(dataout), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_key_tick", 32'(key_tick), 0);
    chk("reset_rx_done", 32'(rx_done_tick), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    started = 1;

    busy_seen = 0;
    frame(8'h1C, 0, 1, 1, 0);
    chk("lit_make_1C", 32'(dataout), 32'h1C);
    chk("busy_during_frame", 32'(busy_seen), 1);
    chk("busy_after_frame", 32'(busy), 0);

    frame(8'hF0, 0, 1, 1, 0);
    frame(8'h1C, 0, 1, 1, 0);
    chk("lit_break_1C", 32'(dataout), 32'h00);

    frame(8'h1C, 0, 1, 1, 0);
    frame(8'hF0, 0, 1, 1, 0);
    frame(8'h23, 0, 1, 1, 0);
    chk("lit_break_other", 32'(dataout), 32'h1C);
    frame(8'h23, 0, 1, 1, 0);
    chk("lit_make_23", 32'(dataout), 32'h23);

    frame(8'h1C, 1, 1, 1, 0);
    chk("lit_parity_err", 32'(dataout), 32'h23);

    // Start bit plus five data bits, then the clock stays high.
    q_kind.push_back(2);
    q_byte.push_back(8'h00);
    rx_en = 1'b1;
    send_bits({1'b1, 1'b1, 8'h1B, 1'b0}, 6, 0);
    chk("busy_partial", 32'(busy), 1);
    repeat (2 * TOUT) @(negedge clk);
    chk("timeout_event", q_kind.size(), 0);
    q_kind.delete();
    q_byte.delete();
    chk("busy_after_timeout", 32'(busy), 0);
    frame(8'h1B, 0, 1, 1, 0);
    chk("lit_make_1B", 32'(dataout), 32'h1B);

    busy_seen = 0;
    rx_en = 1'b1;
    ps2d  = 1'b0;
    ps2c  = 1'b0;
    repeat (FILTER_LEN - 2) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    ps2d = 1'b1;
    frame(8'h1C, 0, 1, 0, 0);
    chk("glitch_busy", 32'(busy_seen), 0);
    chk("lit_rx_en_off", 32'(dataout), 32'h1B);

    frame(8'hE0, 0, 1, 1, 0);
    frame(8'h75, 0, 1, 1, 0);
    chk("lit_e0_75", 32'(dataout), 32'h75);
`ifdef PS2_EXT_CODE_EN
    chk("lit_ext", 32'(ext), 1);
`endif

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) b = 8'hF0;
      else if (sel == 2) b = 8'hE0;
      else if (sel < 6) b = last_make;
      else begin
        b = pool[$urandom_range(0, 3)];
        last_make = b;
      end
      sel = $urandom_range(0, 9);
      case (sel)
        0: frame(b, 1, 1, 1, 0);
        1: frame(b, 0, 0, 1, 0);
        2: frame(b, 0, 1, 0, 0);
        3: frame(b, 0, 1, 1, 1);
        default: frame(b, 0, 1, 1, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
